// File: rtl/softmax_pkg.sv
// Shared constants and types for the softmax front end (Q4.12 scores, 32-element vectors).
// Includes the saturating x - max helper used on the drain path.
package softmax_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int FRAC_BITS = 12;
  localparam int N_ELEMS   = 32;
  localparam int IDX_W     = $clog2(N_ELEMS);

  typedef logic signed [BIT_WIDTH-1:0] data_t;
  typedef logic [IDX_W-1:0]            idx_t;
  typedef enum logic {LOAD = 1'b0, DRAIN = 1'b1} state_t;

  localparam idx_t LAST_IDX = idx_t'(N_ELEMS - 1);

  // x <= max always holds, so the only overflow is below the most negative code.
  function automatic data_t sat_sub(input data_t x, input data_t m);
    logic signed [BIT_WIDTH:0] diff;
    diff = {x[BIT_WIDTH-1], x} - {m[BIT_WIDTH-1], m};
    if (diff[BIT_WIDTH] != diff[BIT_WIDTH-1]) begin
      return {1'b1, {(BIT_WIDTH-1){1'b0}}};
    end
    return diff[BIT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/softmax_vec_buf.sv
// Vector buffer: one synchronous write port, combinational read port, no reset on the array.
// Latency: write visible on the read port the cycle after the write edge; no backpressure.
module softmax_vec_buf
  import softmax_pkg::*;
(
  input  logic  i_clk,
  input  logic  we,
  input  idx_t  waddr,
  input  data_t wdata,
  input  idx_t  raddr,
  output data_t rdata
);

  data_t mem [N_ELEMS];

  always_ff @(posedge i_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/softmax_max_subtract.sv
// Loads a vector while tracking its max, then streams sat(x[k] - max) one per cycle.
// Latency: first output 1 cycle after last accept; o_ready low during drain, output has no stall.
module softmax_max_subtract
  import softmax_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [BIT_WIDTH-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [BIT_WIDTH-1:0] o_data,
  output logic                 o_last,
  output logic [BIT_WIDTH-1:0] o_max
);

  state_t state_q, state_d;
  idx_t   wr_cnt_q, wr_cnt_d;
  idx_t   rd_cnt_q, rd_cnt_d;
  data_t  run_max_q, run_max_d;
  data_t  max_q, max_d;
  data_t  data_q, data_d;
  logic   valid_q, valid_d;
  logic   last_q, last_d;

  logic   accept;
  data_t  in_data;
  data_t  rd_data;
  data_t  next_max;

  assign in_data = data_t'(i_data);
  assign accept  = i_valid && (state_q == LOAD);

  // First element seeds the max so a previous vector's value never leaks in.
  assign next_max = ((wr_cnt_q == '0) || (in_data > run_max_q)) ? in_data : run_max_q;

  softmax_vec_buf u_buf (
    .i_clk (i_clk),
    .we    (accept),
    .waddr (wr_cnt_q),
    .wdata (in_data),
    .raddr (rd_cnt_q),
    .rdata (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    run_max_d = run_max_q;
    max_d     = max_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          run_max_d = next_max;
          if (wr_cnt_q == LAST_IDX) begin
            state_d  = DRAIN;
            wr_cnt_d = '0;
            max_d    = next_max;
          end else begin
            wr_cnt_d = wr_cnt_q + idx_t'(1);
          end
        end
      end
      DRAIN: begin
        valid_d = 1'b1;
        data_d  = sat_sub(rd_data, max_q);
        if (rd_cnt_q == LAST_IDX) begin
          last_d   = 1'b1;
          state_d  = LOAD;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + idx_t'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= LOAD;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      run_max_q <= '0;
      max_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      run_max_q <= run_max_d;
      max_q     <= max_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

  assign o_ready = (state_q == LOAD);
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_max   = max_q;

endmodule

// File: tb/tb_softmax_max_subtract.sv
// Bench for softmax_max_subtract: table vectors, random vectors against an arithmetic model,
// plus drop, back-to-back and reset sequences.
module tb_softmax_max_subtract;

  localparam int N = 32;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [15:0] i_data;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_data;
  logic        o_last;
  logic [15:0] o_max;

  softmax_max_subtract dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_max   (o_max)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] out_q[$];
  logic [15:0] omax_q[$];
  logic        olast_q[$];
  int          ocyc_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] emax_q[$];
  int          acc_q[$];
  int          first_acc;
  logic [15:0] vec[N];

  typedef struct packed {
    logic [15:0] first;
    logic [15:0] rest;
    logic [15:0] emax;
    logic [15:0] efirst;
    logic [15:0] erest;
    logic        gap;
  } tv_t;
  tv_t tbl[10];

  always @(negedge i_clk) begin
    if (i_rst_n && o_valid) begin
      out_q.push_back(o_data);
      omax_q.push_back(o_max);
      olast_q.push_back(o_last);
      ocyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_q();
    out_q.delete(); omax_q.delete(); olast_q.delete(); ocyc_q.delete();
    exp_q.delete(); emax_q.delete(); acc_q.delete();
  endtask

  task automatic send_vec(input int n, input bit gap);
    bit ok;
    int guard;
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1;
      i_data  = vec[i];
      ok      = 1'b0;
      guard   = 0;
      while (!ok && guard < 300) begin
        @(negedge i_clk);
        ok = o_ready;
        @(posedge i_clk);
        #1;
        guard++;
      end
      if (!ok) begin
        chk("accept_timeout", 64'd0, 64'd1);
        i_valid = 1'b0;
        return;
      end
      if (i == 0) first_acc = cyc;
      if (i == N - 1) acc_q.push_back(cyc);
      i_valid = 1'b0;
      if (gap) begin
        @(posedge i_clk);
        #1;
      end
    end
  endtask

  // Reference: max over the vector, then plain integer difference clamped at -32768.
  task automatic model_push();
    int mx;
    int v;
    int d;
    mx = int'($signed(vec[0]));
    for (int i = 1; i < N; i++) begin
      v = int'($signed(vec[i]));
      if (v > mx) mx = v;
    end
    for (int i = 0; i < N; i++) begin
      d = int'($signed(vec[i])) - mx;
      if (d < -32768) d = -32768;
      exp_q.push_back(16'(d));
      emax_q.push_back(16'(mx));
    end
  endtask

  task automatic check_out(input string nm, input int nvecs);
    int tot;
    int guard;
    int b;
    logic [63:0] act;
    logic [63:0] exp;
    tot   = nvecs * N;
    guard = 0;
    while (out_q.size() < tot && guard < 100 + nvecs * 80) begin
      @(posedge i_clk);
      guard++;
    end
    repeat (3) @(posedge i_clk);
    chk({nm, " count"}, 64'(out_q.size()), 64'(tot));
    for (int k = 0; k < tot && k < out_q.size(); k++) begin
      b = k / N;
      if (k % N == 0) chk({nm, " latency"}, 64'(ocyc_q[k]), 64'(acc_q[b] + 1));
      act = {16'(ocyc_q[k] - ocyc_q[b * N]), 15'b0, olast_q[k], omax_q[k], out_q[k]};
      exp = {16'(k % N), 15'b0, (k % N == N - 1), emax_q[k], exp_q[k]};
      chk({nm, " elem"}, act, exp);
    end
    @(negedge i_clk);
    chk({nm, " idle valid"}, 64'(o_valid), 64'd0);
    if (out_q.size() > 0) chk({nm, " hold"}, 64'(o_data), 64'(out_q[out_q.size() - 1]));
    clear_q();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) begin
      vec[i] = 16'(i);
      exp_q.push_back(16'(i - 31));
      emax_q.push_back(16'd31);
    end
  endtask

  task automatic load_random(input bit neg);
    for (int i = 0; i < N; i++) begin
      vec[i] = 16'($urandom_range(0, 65535));
      if (neg) vec[i][15] = 1'b1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h1000, 16'h1000, 16'h1000, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h8000, 1'b1};
    tbl[2] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000, 1'b0};
    tbl[3] = '{16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b1};
    tbl[4] = '{16'hFFFF, 16'h0001, 16'h0001, 16'hFFFE, 16'h0000, 1'b0};
    tbl[5] = '{16'h0000, 16'hC000, 16'h0000, 16'h0000, 16'hC000, 1'b1};
    tbl[6] = '{16'h4000, 16'hC000, 16'h4000, 16'h0000, 16'h8000, 1'b0};
    tbl[7] = '{16'h4001, 16'hC000, 16'h4001, 16'h0000, 16'h8000, 1'b1};
    tbl[8] = '{16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000, 1'b0};
    tbl[9] = '{16'hC000, 16'hC001, 16'hC001, 16'hFFFF, 16'h0000, 1'b1};

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = 16'h0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset o_ready", 64'(o_ready), 64'd1);
    chk("reset o_valid", 64'(o_valid), 64'd0);
    chk("reset o_data", 64'(o_data), 64'd0);
    chk("reset o_last", 64'(o_last), 64'd0);
    chk("reset o_max", 64'(o_max), 64'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    load_ramp();
    send_vec(N, 1'b0);
    check_out("ramp", 1);

    for (int t = 0; t < 10; t++) begin
      vec[0] = tbl[t].first;
      exp_q.push_back(tbl[t].efirst);
      emax_q.push_back(tbl[t].emax);
      for (int i = 1; i < N; i++) begin
        vec[i] = tbl[t].rest;
        exp_q.push_back(tbl[t].erest);
        emax_q.push_back(tbl[t].emax);
      end
      send_vec(N, tbl[t].gap);
      check_out($sformatf("table%0d", t), 1);
    end

    for (int r = 0; r < 4; r++) begin
      load_random(r < 2);
      model_push();
      send_vec(N, 1'b0);
      check_out($sformatf("rand%0d cont", r), 1);
      model_push();
      send_vec(N, 1'b1);
      check_out($sformatf("rand%0d gap", r), 1);
    end

    // Pulses while o_ready is low must be dropped and must not disturb the next vector.
    load_random(1'b1);
    model_push();
    send_vec(N, 1'b0);
    for (int k = 0; k < 30; k++) begin
      i_valid = (k % 2 == 0);
      i_data  = 16'h7FFF;
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    check_out("drop", 1);
    load_random(1'b1);
    model_push();
    send_vec(N, 1'b0);
    check_out("after drop", 1);

    load_random(1'b0);
    model_push();
    send_vec(N, 1'b0);
    load_random(1'b0);
    model_push();
    send_vec(N, 1'b0);
    chk("b2b first accept", 64'(first_acc), 64'(ocyc_q[N - 1] + 1));
    check_out("b2b", 2);

    for (int i = 0; i < N; i++) vec[i] = 16'h7000;
    send_vec(10, 1'b0);
    i_rst_n = 1'b0;
    #1;
    chk("rst load o_ready", 64'(o_ready), 64'd1);
    chk("rst load o_valid", 64'(o_valid), 64'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    clear_q();
    load_ramp();
    send_vec(N, 1'b0);
    check_out("rst load ramp", 1);

    load_random(1'b0);
    send_vec(N, 1'b0);
    repeat (5) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("rst drain o_valid", 64'(o_valid), 64'd0);
    chk("rst drain o_data", 64'(o_data), 64'd0);
    chk("rst drain o_max", 64'(o_max), 64'd0);
    chk("rst drain o_ready", 64'(o_ready), 64'd1);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    clear_q();
    load_ramp();
    send_vec(N, 1'b1);
    check_out("rst drain ramp", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
